// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit with HI/LO registers.
// A mult/div result is computed when the op is accepted and parked in temp
// registers. A counter then models the iterative latency, and the result
// commits to HI/LO when the counter reaches its last cycle.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] MDUOut
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo, tmp_hi, tmp_lo;
  logic             tmp_vld;   // cleared for divide-by-zero so HI/LO stay put
  logic             accept;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq_s, ur_s, q_s, r_s, q_u, r_u;

  assign Busy   = (cnt != '0);
  assign accept = Start && !Req && !Busy && (MDUOp >= OP_MULT) && (MDUOp <= OP_MTLO);

  // Products: sign-extend to 64 bits for mult, zero-extend for multu.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divide on magnitudes and then restore signs. This truncates toward zero,
  // gives the remainder the sign of the dividend, and makes 0x80000000 / -1
  // come out as 0x80000000 rem 0 with no special case.
  always_comb begin
    abs_a = A[31] ? (32'd0 - A) : A;
    abs_b = B[31] ? (32'd0 - B) : B;
    uq_s  = 32'd0;
    ur_s  = 32'd0;
    q_u   = 32'd0;
    r_u   = 32'd0;
    if (B != 32'd0) begin
      uq_s = abs_a / abs_b;
      ur_s = abs_a % abs_b;
      q_u  = A / B;
      r_u  = A % B;
    end
    q_s = (A[31] ^ B[31]) ? (32'd0 - uq_s) : uq_s;
    r_s = A[31] ? (32'd0 - ur_s) : ur_s;
  end

  // Accept new ops, count down in-flight ops, and commit on the final cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      tmp_hi  <= '0;
      tmp_lo  <= '0;
      tmp_vld <= 1'b0;
    end else if (Busy) begin
      if (cnt == CNT_W'(1) && tmp_vld) begin
        hi <= tmp_hi;
        lo <= tmp_lo;
      end
      cnt <= cnt - CNT_W'(1);
    end else if (accept) begin
      case (MDUOp)
        OP_MULT: begin
          {tmp_hi, tmp_lo} <= prod_s;
          tmp_vld <= 1'b1;
          cnt     <= CNT_W'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {tmp_hi, tmp_lo} <= prod_u;
          tmp_vld <= 1'b1;
          cnt     <= CNT_W'(MULT_CYCLES);
        end
        OP_DIV: begin
          tmp_hi  <= r_s;
          tmp_lo  <= q_s;
          tmp_vld <= (B != 32'd0);
          cnt     <= CNT_W'(DIV_CYCLES);
        end
        OP_DIVU: begin
          tmp_hi  <= r_u;
          tmp_lo  <= q_u;
          tmp_vld <= (B != 32'd0);
          cnt     <= CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        default: ;
      endcase
    end
  end

  // Read port: HI/LO select is purely combinational on MDUOp.
  always_comb begin
    case (MDUOp)
      OP_MFHI: MDUOut = hi;
      OP_MFLO: MDUOut = lo;
      default: MDUOut = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed checks of e_mdu latency, results, masking and reset.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDUOp;
  logic        Start, Req;
  logic        Busy;
  logic [31:0] MDUOut;

  int checks = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
    .Start(Start), .Req(Req), .Busy(Busy), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] op, input logic [31:0] exp);
    MDUOp = op;
    Start = 1'b0;
    #1;
    chk(tag, MDUOut, exp);
  endtask

  // Accept an op at the next edge k, then check Busy after edges k..k+n-1 and
  // that mfhi still returns old_hi. Busy must be low after edge k+n.
  // When inject is set, a mtlo of 0xDEAD is offered after edge k+1 and must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] old_hi,
                        input bit req_during, input bit inject);
    MDUOp = op; A = a; B = b; Start = 1'b1; Req = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      MDUOp = 4'd7; Start = 1'b0; Req = req_during;
      #1;
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      chk({tag, "_oldhi"}, MDUOut, old_hi);
      if (inject && i == 1) begin
        MDUOp = 4'd6; A = 32'h0000DEAD; Start = 1'b1;
      end
      step();
    end
    Req = 1'b0; Start = 1'b0;
    chk({tag, "_done"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; A = '0; B = '0; MDUOp = '0; Start = 1'b0; Req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    rd("rst_hi", 4'd7, 32'd0);
    rd("rst_lo", 4'd8, 32'd0);
    reset = 1'b1;

    // mtlo masked by Req, then accepted
    MDUOp = 4'd6; A = 32'h1234; Start = 1'b1; Req = 1'b1;
    step();
    Req = 1'b0;
    rd("mtlo_req", 4'd8, 32'd0);
    MDUOp = 4'd6; A = 32'h1234; Start = 1'b1;
    step();
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);
    rd("mtlo", 4'd8, 32'h1234);
    MDUOp = 4'd5; A = 32'h5555; Start = 1'b1;
    step();
    rd("mthi", 4'd7, 32'h5555);
    rd("mthi_start_noeffect", 4'd7, 32'h5555);
    Start = 1'b1; Req = 1'b1; MDUOp = 4'd7; #1;
    chk("read_ignores_start_req", MDUOut, 32'h5555);
    Start = 1'b0; Req = 1'b0;

    // mult signed with an ignored mtlo attempt during Busy
    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h5555, 1'b0, 1'b1);
    rd("mult_hi", 4'd7, 32'hFFFFFFFF);
    rd("mult_lo", 4'd8, 32'hFFFFFFFA);

    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 1'b0, 1'b0);
    rd("multu_hi", 4'd7, 32'h00000002);
    rd("multu_lo", 4'd8, 32'hFFFFFFFA);

    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h2, 1'b0, 1'b0);
    rd("div_hi", 4'd7, 32'hFFFFFFFF);
    rd("div_lo", 4'd8, 32'hFFFFFFFD);

    run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 1'b0, 1'b0);
    rd("divu0_hi", 4'd7, 32'hFFFFFFFF);
    rd("divu0_lo", 4'd8, 32'hFFFFFFFD);

    run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 1'b0, 1'b0);
    rd("divovf_hi", 4'd7, 32'h0);
    rd("divovf_lo", 4'd8, 32'h80000000);

    // Req during flight must not cancel the commit
    run_op("divu_req", 4'd4, 32'd100, 32'd7, 10, 32'h0, 1'b1, 1'b0);
    rd("divu_req_hi", 4'd7, 32'd2);
    rd("divu_req_lo", 4'd8, 32'd14);

    run_op("div_neg", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd2, 1'b0, 1'b0);
    rd("div_neg_hi", 4'd7, 32'd1);
    rd("div_neg_lo", 4'd8, 32'hFFFFFFFD);

    // Asynchronous reset in the middle of a divide
    MDUOp = 4'd3; A = 32'd9; B = 32'd2; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    rd("arst_hi", 4'd7, 32'd0);
    rd("arst_lo", 4'd8, 32'd0);
    step();
    reset = 1'b1;
    repeat (10) step();
    rd("arst_nocommit_hi", 4'd7, 32'd0);
    rd("arst_nocommit_lo", 4'd8, 32'd0);
    MDUOp = 4'd5; A = 32'hCAFE; Start = 1'b1;
    step();
    rd("post_rst_accept", 4'd7, 32'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: number of Busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: number of Busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port A  input  32  rs operand: multiplicand, dividend, or mthi/mtlo source.
REQ-006 SHALL have port B  input  32  rt operand: multiplier or divisor.
REQ-007 SHALL have port MDUOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none.
REQ-008 SHALL have port Start  input  1  qualifies ops 1-6 in the current cycle.
REQ-009 SHALL have port Req  input  1  exception/interrupt flush; suppresses any op presented this cycle.
REQ-010 SHALL have port Busy  output  1  a mult/div is in flight; the hazard unit stalls the MDU instruction in E while Busy or Start is high.
REQ-011 SHALL have port MDUOut  output  32  mfhi/mflo read data.

Function
REQ-012 Accept: an op 1-6 SHALL be accepted at a rising edge only when Start=1, Req=0 and Busy=0; in every other case Start SHALL be ignored with no state change.
REQ-013 mult/multu accept SHALL capture the 64-bit product of A and B (signed for mult, unsigned for multu) into internal temp registers, load the counter with MULT_CYCLES, and set Busy.
REQ-014 div/divu accept SHALL capture quotient and remainder (signed for div, unsigned for divu) into temp registers, load the counter with DIV_CYCLES, and set Busy.
REQ-015 Signed divide SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-016 0x80000000 div 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-017 Divide by zero (B=0) SHALL still run DIV_CYCLES with Busy high, and SHALL leave HI and LO unchanged at completion.
REQ-018 Timing: for an accept at edge k, Busy SHALL be 1 after edges k through k+N-1 (N = MULT_CYCLES or DIV_CYCLES) and 0 after edge k+N.
REQ-019 Commit at edge k+N: mult/multu SHALL write HI=product[63:32] and LO=product[31:0]; div/divu SHALL write HI=remainder and LO=quotient.
REQ-020 Commit SHALL NOT be cancelled by a Req asserted after acceptance; Req only masks new ops.
REQ-021 mthi/mtlo accept SHALL write A into HI/LO at that edge, take one cycle, and leave Busy at 0.
REQ-022 Reads: MDUOut SHALL be combinational: HI when MDUOp=7, LO when MDUOp=8, 0 otherwise; Start and Req SHALL NOT affect it.
REQ-023 MDUOut SHALL return the previously committed HI/LO while Busy=1; the new value SHALL be visible in the cycle after the commit edge.
REQ-024 Only the mult/div commit, mthi and mtlo SHALL modify HI/LO; an op accepted in the same cycle as a commit cannot occur, because Busy=1 blocks acceptance.
REQ-025 The counter SHALL be at least 4 bits, SHALL decrement once per cycle while Busy, and SHALL never wrap below 0.

Reset
REQ-026 reset=0 SHALL immediately and asynchronously clear HI, LO, the temp registers and the counter to 0 and force Busy=0, including mid-operation; the in-flight result SHALL be discarded.
REQ-027 After reset deasserts, the first rising edge SHALL be able to accept a new op.

Verification
REQ-028 mult with A=0xFFFFFFFE, B=3 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 multu with A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA; mfhi during Busy returns the old HI.
REQ-030 div with A=-7 (0xFFFFFFF9), B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 -> Busy high for 10 cycles, HI/LO unchanged.
REQ-031 mtlo with A=0x1234 and Start=1, Req=1 -> LO unchanged; repeated with Req=0 -> mflo reads 0x1234 on the next cycle with Busy=0.
REQ-032 Start a div, pull reset low at cycle 4 -> Busy=0 and HI=LO=0 immediately; no commit follows; Start asserted at cycle 2 of a mult -> ignored, only the mult result commits.
